spi_master: RTL and testbench

Single-clock SPI master that issues 10-bit command frames (2-bit opcode plus 8-bit payload) on MOSI/SS_n and, for read-data commands, captures the 8-bit reply on MISO. It is the initiator counterpart of the SPI-slave/RAM wrapper. A host-side valid/ready port accepts one command at a time, and read results are returned on a one-cycle strobe. The SPI serial clock is the system `clk`: one bit is transferred per `clk` cycle.

---
 rtl/spi_master.sv | 178 +++++++++++++++++
 tb/tb_spi_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_master
// Purpose  : SPI initiator that sends 10-bit command frames {op[1:0], data[7:0]}
//            MSB first and, for read-data commands (op 2'b11), captures an
//            8-bit reply from MISO after a programmable turnaround. The serial
//            clock is the system clock: one bit moves per clk cycle.
// Ports    : clk, rst_n            - clock / asynchronous active-low reset
//            cmd_valid, cmd_ready  - host command handshake (ready only when idle)
//            cmd_op, cmd_data      - opcode and payload, latched on accept
//            rd_valid, rd_data     - one-cycle read strobe, data held until next
//            SS_n, MOSI            - registered slave select / serial data out
//            MISO                  - serial data in, sampled on rising clk
// Revision : 1.0 - initial release
// ============================================================================
module spi_master #(
  parameter int RD_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_start = 3'd1;
  localparam logic [2:0] c_st_shift = 3'd2;
  localparam logic [2:0] c_st_turn  = 3'd3;
  localparam logic [2:0] c_st_recv  = 3'd4;
  localparam logic [2:0] c_st_end   = 3'd5;

  localparam logic [1:0] c_op_rd_data = 2'b11;
  localparam logic [3:0] c_shift_last = 4'd9;
  localparam logic [3:0] c_recv_last  = 4'd7;
  localparam bit         c_has_turn   = (RD_WAIT != 0);
  localparam logic [3:0] c_turn_last  = c_has_turn ? 4'(RD_WAIT - 1) : 4'd0;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [3:0] r_cnt;
  logic [9:0] r_tx;
  logic [6:0] r_rx;
  logic [1:0] r_op;
  logic       r_ss_n;
  logic       r_mosi;
  logic       r_rd_valid;
  logic [7:0] r_rd_data;
  logic       w_ss_n_nxt;
  logic       w_mosi_nxt;
  logic       w_accept;

  assign SS_n     = r_ss_n;
  assign MOSI     = r_mosi;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign w_accept = (r_state == c_st_idle) && cmd_valid;

  // State register and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_cnt      <= 4'd0;
      r_tx       <= 10'd0;
      r_rx       <= 7'd0;
      r_op       <= 2'd0;
      r_ss_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_ss_n  <= w_ss_n_nxt;
      r_mosi  <= w_mosi_nxt;

      // Each phase counts from zero on entry
      if ((w_state_nxt != r_state) || (r_state == c_st_idle)) begin
        r_cnt <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end

      // The frame leaves MSB first; the shift during START lines up
      // frame[8] for the second SHIFT cycle.
      if (w_accept) begin
        r_tx <= {cmd_op, cmd_data};
        r_op <= cmd_op;
      end else if ((r_state == c_st_start) || (r_state == c_st_shift)) begin
        r_tx <= {r_tx[8:0], 1'b0};
      end

      if (r_state == c_st_recv) begin
        r_rx <= {r_rx[5:0], MISO};
      end

      // The eighth sample is folded in directly so the byte lands in END
      r_rd_valid <= (r_state == c_st_recv) && (w_state_nxt == c_st_end);
      if ((r_state == c_st_recv) && (w_state_nxt == c_st_end)) begin
        r_rd_data <= {r_rx, MISO};
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (cmd_valid) begin
          w_state_nxt = c_st_start;
        end
      end
      c_st_start: begin
        w_state_nxt = c_st_shift;
      end
      c_st_shift: begin
        if (r_cnt == c_shift_last) begin
          if (r_op == c_op_rd_data) begin
            w_state_nxt = c_has_turn ? c_st_turn : c_st_recv;
          end else begin
            w_state_nxt = c_st_end;
          end
        end
      end
      c_st_turn: begin
        if (r_cnt == c_turn_last) begin
          w_state_nxt = c_st_recv;
        end
      end
      c_st_recv: begin
        if (r_cnt == c_recv_last) begin
          w_state_nxt = c_st_end;
        end
      end
      c_st_end: begin
        w_state_nxt = c_st_idle;
      end
      default: begin
        w_state_nxt = c_st_idle;
      end
    endcase
  end

  // Output logic: SS_n/MOSI are registered, so they are derived from the
  // state being entered rather than the current one.
  always_comb begin
    cmd_ready  = (r_state == c_st_idle);
    w_ss_n_nxt = 1'b1;
    w_mosi_nxt = 1'b0;
    case (w_state_nxt)
      c_st_start: begin
        // START is only entered from an accept, so the frame MSB is
        // still on the command inputs, not yet in r_tx.
        w_ss_n_nxt = 1'b0;
        w_mosi_nxt = cmd_op[1];
      end
      c_st_shift: begin
        w_ss_n_nxt = 1'b0;
        w_mosi_nxt = r_tx[9];
      end
      c_st_turn, c_st_recv: begin
        w_ss_n_nxt = 1'b0;
      end
      default: begin
        w_ss_n_nxt = 1'b1;
        w_mosi_nxt = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master
// Purpose  : Self-checking bench for spi_master. A transaction-level model
//            (accept time, frame contents, bench-side slave RAM) predicts the
//            pins of the RD_WAIT=2 instance every cycle; directed literal
//            checks pin the model and cover the RD_WAIT=0 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master;

  localparam int RW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       ss_n;
  logic       mosi;
  logic       miso = 1'b1;

  logic       b_cmd_valid;
  logic [1:0] b_cmd_op;
  logic [7:0] b_cmd_data;
  logic       b_cmd_ready;
  logic       b_rd_valid;
  logic [7:0] b_rd_data;
  logic       b_ss_n;
  logic       b_mosi;
  logic       b_miso = 1'b1;

  always #5 clk = ~clk;

  spi_master #(.RD_WAIT(RW)) u_dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
  );

  spi_master #(.RD_WAIT(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(b_cmd_valid), .cmd_op(b_cmd_op),
    .cmd_data(b_cmd_data), .cmd_ready(b_cmd_ready), .rd_valid(b_rd_valid),
    .rd_data(b_rd_data), .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(b_miso)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Transaction-level model: n = cycles since the accept edge (START is n=1)
  bit         m_busy    = 1'b0;
  int         m_n       = 0;
  int         m_len     = 12;
  logic [1:0] m_op      = 2'd0;
  logic [7:0] m_data    = 8'h00;
  logic [7:0] m_byte    = 8'h00;
  logic [7:0] m_rdq     = 8'h00;
  logic [7:0] m_wr_addr = 8'h00;
  logic [7:0] m_rd_addr = 8'h00;
  logic [7:0] mem [256] = '{default: 8'h00};
  int         acc_q [$];

  // Per-cycle pin history, indexed by the number of rising edges seen
  logic       h_ss  [4096];
  logic       h_mosi[4096];
  logic       h_rv  [4096];
  logic       h_rdy [4096];
  logic [7:0] h_rd  [4096];
  logic       h_bss [4096];
  logic       h_brv [4096];
  logic [7:0] h_brd [4096];

  bit         b_active = 1'b0;
  int         b_t      = 0;
  logic [7:0] b_byte   = 8'h96;

  always @(posedge clk) begin : model
    cyc = cyc + 1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_rdq  = 8'h00;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1'b1;
        m_n    = 1;
        m_op   = cmd_op;
        m_data = cmd_data;
        m_len  = (cmd_op == 2'b11) ? 20 + RW : 12;
        m_byte = mem[m_rd_addr];
        acc_q.push_back(cyc);
      end
    end else begin
      m_n = m_n + 1;
      if (m_n == m_len) begin
        case (m_op)
          2'b00: m_wr_addr = m_data;
          2'b01: mem[m_wr_addr] = m_data;
          2'b10: m_rd_addr = m_data;
          default: m_rdq = m_byte;
        endcase
      end else if (m_n > m_len) begin
        m_busy = 1'b0;
      end
    end
    #1;
    // Slave reply, MSB first, over the 8 cycles after the turnaround;
    // ones elsewhere expose any sample taken at the wrong cycle.
    if (m_busy && m_op == 2'b11 && m_n >= 12 + RW && m_n <= 19 + RW)
      miso = m_byte[19 + RW - m_n];
    else
      miso = 1'b1;
  end

  always @(posedge clk) begin : slave_b
    int k;
    #1;
    k = cyc - b_t + 1;
    if (b_active && k >= 12 && k <= 19) b_miso = b_byte[19 - k];
    else b_miso = 1'b1;
  end

  function automatic logic [11:0] model_exp();
    logic [9:0] f;
    logic       m;
    f = {m_op, m_data};
    if (!m_busy) return {1'b1, 1'b1, 1'b0, 1'b0, m_rdq};
    m = 1'b0;
    if (m_n == 1) m = f[9];
    else if (m_n >= 2 && m_n <= 11) m = f[11 - m_n];
    return {1'b0, (m_n >= m_len), m, (m_op == 2'b11 && m_n == m_len), m_rdq};
  endfunction

  always @(negedge clk) begin : compare
    logic [11:0] act;
    logic [11:0] exp;
    if (cyc < 4096) begin
      h_ss[cyc]   = ss_n;
      h_mosi[cyc] = mosi;
      h_rv[cyc]   = rd_valid;
      h_rdy[cyc]  = cmd_ready;
      h_rd[cyc]   = rd_data;
      h_bss[cyc]  = b_ss_n;
      h_brv[cyc]  = b_rd_valid;
      h_brd[cyc]  = b_rd_data;
    end
    if (rst_n) begin
      exp = model_exp();
      act = {cmd_ready, ss_n, mosi, rd_valid, rd_data};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model cyc=%0d n=%0d {ready,ss_n,mosi,rd_valid,rd_data} actual=%b required=%b",
                 cyc, m_n, act, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int ix(input int t, input int k);
    return t + k - 1;
  endfunction

  task automatic send_a(input logic [1:0] op, input logic [7:0] d, output int t);
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("send_a_ready_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    t         = cyc + 1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_data  = ~d;
  endtask

  task automatic send_b(input logic [1:0] op, input logic [7:0] d, output int t);
    int w;
    w = 0;
    @(negedge clk);
    while (!b_cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("send_b_ready_timeout", 32'd0, 32'd1);
    b_cmd_valid = 1'b1;
    b_cmd_op    = op;
    b_cmd_data  = d;
    t           = cyc + 1;
    @(posedge clk);
    #1;
    b_cmd_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int         t;
    int         lows;
    logic [9:0] v;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;
    b_cmd_valid = 1'b0; b_cmd_op = 2'd0; b_cmd_data = 8'h00;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_ss_n", ss_n, 1);
    chk("reset_mosi", mosi, 0);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 8'h00);
    #2 rst_n = 1'b1;

    // Write address 0x3A
    send_a(2'b00, 8'h3A, t);
    repeat (14) @(negedge clk);
    v = '0;
    for (int k = 2; k <= 11; k++) v = {v[8:0], h_mosi[ix(t, k)]};
    chk("wa_mosi_bits", v, 10'b0000111010);
    lows = 0;
    for (int k = 0; k <= 13; k++) if (!h_ss[ix(t, k)]) lows++;
    chk("wa_ss_low_count", lows, 11);
    chk("wa_ss_first_low", h_ss[ix(t, 1)], 0);
    chk("wa_ss_high_end", h_ss[ix(t, 12)], 1);
    chk("wa_ready_end", h_rdy[ix(t, 12)], 0);
    chk("wa_ready_back", h_rdy[ix(t, 13)], 1);
    lows = 0;
    for (int k = 1; k <= 13; k++) if (h_rv[ix(t, k)]) lows++;
    chk("wa_no_rd_valid", lows, 0);

    // Read 0xC5 back through the slave RAM model
    send_a(2'b00, 8'h3A, t);
    send_a(2'b01, 8'hC5, t);
    send_a(2'b10, 8'h3A, t);
    send_a(2'b11, 8'hFF, t);
    repeat (24) @(negedge clk);
    chk("rd_data_c5", h_rd[ix(t, 22)], 8'hC5);
    chk("rd_valid_t22", h_rv[ix(t, 22)], 1);
    chk("rd_valid_t21", h_rv[ix(t, 21)], 0);
    chk("rd_valid_t23", h_rv[ix(t, 23)], 0);
    lows = 0;
    for (int k = 0; k <= 23; k++) if (!h_ss[ix(t, k)]) lows++;
    chk("rd_ss_low_count", lows, 21);
    chk("rd_ss_high_t22", h_ss[ix(t, 22)], 1);

    // Full write/read sequence
    send_a(2'b00, 8'h10, t);
    send_a(2'b01, 8'hA7, t);
    send_a(2'b10, 8'h10, t);
    send_a(2'b11, 8'h00, t);
    repeat (24) @(negedge clk);
    chk("seq_rd_data_a7", rd_data, 8'hA7);

    // cmd_valid held high with a payload change every cycle
    acc_q.delete();
    cmd_valid = 1'b1;
    for (int i = 0; i < 41; i++) begin
      cmd_op   = 2'(i % 3);
      cmd_data = 8'(29 * i + 3);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_accept_count", acc_q.size(), 4);
    for (int i = 1; i < acc_q.size(); i++) chk("b2b_period", acc_q[i] - acc_q[i-1], 13);
    repeat (15) @(negedge clk);

    // Reset in the middle of a write frame
    send_a(2'b00, 8'hE1, t);
    repeat (5) @(posedge clk);
    #1 chk("abort_pre_mosi", mosi, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", ss_n, 1);
    chk("abort_mosi", mosi, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_rd_data", rd_data, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 8'h5C;
    t = cyc + 1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (14) @(negedge clk);
    v = '0;
    for (int k = 2; k <= 11; k++) v = {v[8:0], h_mosi[ix(t, k)]};
    chk("post_reset_mosi_bits", v, 10'b0001011100);
    lows = 0;
    for (int k = 0; k <= 13; k++) if (!h_ss[ix(t, k)]) lows++;
    chk("post_reset_ss_low_count", lows, 11);

    // RD_WAIT=0 instance: reply sampled from T+12, strobe at T+20
    b_byte   = 8'h96;
    b_active = 1'b1;
    send_b(2'b11, 8'h00, b_t);
    repeat (22) @(negedge clk);
    chk("rw0_rd_valid_t20", h_brv[ix(b_t, 20)], 1);
    chk("rw0_rd_valid_t19", h_brv[ix(b_t, 19)], 0);
    chk("rw0_rd_valid_t21", h_brv[ix(b_t, 21)], 0);
    chk("rw0_rd_data", h_brd[ix(b_t, 20)], 8'h96);
    chk("rw0_ss_low_t19", h_bss[ix(b_t, 19)], 0);
    chk("rw0_ss_high_t20", h_bss[ix(b_t, 20)], 1);
    b_active = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
